// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU operand/result and response signals between the issue controller
// and its surroundings. The controller uses the slave modport.
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] adder_rsv;
    logic [31:0] shifter_rsv;
    logic [31:0] comparator_rsv;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_we;
    logic        rsp_illegal;

    modport slave (
        input  req_valid, req_instr, req_rs1, req_rs2,
        input  adder_rsv, shifter_rsv, comparator_rsv, rsp_ready,
        output req_ready, alu_op1, alu_op2, alu_funct3, alu_funct7,
        output rsp_valid, rsp_rd, rsp_data, rsp_we, rsp_illegal
    );

    modport master (
        output req_valid, req_instr, req_rs1, req_rs2,
        output adder_rsv, shifter_rsv, comparator_rsv, rsp_ready,
        input  req_ready, alu_op1, alu_op2, alu_funct3, alu_funct7,
        input  rsp_valid, rsp_rd, rsp_data, rsp_we, rsp_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes an OP/OP-IMM request, holds operands on the ALU
// for a programmable settle time, then returns the selected result with rd.
module alu_issue_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input logic            clk,
    input logic            reset,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // Settle cycles plus the final sampling cycle give EXEC_CYCLES+1 latency.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [4:0]  rd_q;
    logic        illegal_q;

    logic [6:0]  opcode;
    logic [2:0]  dec_f3;
    logic        is_op;
    logic        is_imm;
    logic        legal;
    logic [31:0] dec_op2;
    logic        dec_f7;
    logic [31:0] sel_result;
    logic        accept;

    assign bus.req_ready = (state == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        opcode  = bus.req_instr[6:0];
        dec_f3  = bus.req_instr[14:12];
        is_op   = (opcode == 7'b0110011);
        is_imm  = (opcode == 7'b0010011);
        legal   = is_op || is_imm;
        dec_op2 = '0;
        dec_f7  = 1'b0;
        if (is_op) begin
            dec_op2 = bus.req_rs2;
            dec_f7  = bus.req_instr[30];
        end else if (is_imm) begin
            if (dec_f3 == 3'b001 || dec_f3 == 3'b101)
                dec_op2 = {27'd0, bus.req_instr[24:20]};
            else
                dec_op2 = {{20{bus.req_instr[31]}}, bus.req_instr[31:20]};
            // Only the right-shift immediates carry the arithmetic bit; there is no SUBI.
            dec_f7 = (dec_f3 == 3'b101) && bus.req_instr[30];
        end
    end

    always_comb begin
        sel_result = '0;
        case (bus.alu_funct3)
            3'b001, 3'b101: sel_result = bus.shifter_rsv;
            3'b010, 3'b011: sel_result = bus.comparator_rsv;
            default:        sel_result = bus.adder_rsv;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            rd_q            <= '0;
            illegal_q       <= 1'b0;
            bus.alu_op1     <= '0;
            bus.alu_op2     <= '0;
            bus.alu_funct3  <= '0;
            bus.alu_funct7  <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rd      <= '0;
            bus.rsp_data    <= '0;
            bus.rsp_we      <= 1'b0;
            bus.rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.alu_op1    <= legal ? bus.req_rs1 : '0;
                        bus.alu_op2    <= dec_op2;
                        bus.alu_funct3 <= legal ? dec_f3 : '0;
                        bus.alu_funct7 <= dec_f7;
                        rd_q           <= bus.req_instr[11:7];
                        illegal_q      <= !legal;
                        cnt            <= CNT_LOAD;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        bus.rsp_data    <= illegal_q ? '0 : sel_result;
                        bus.rsp_rd      <= rd_q;
                        bus.rsp_we      <= !illegal_q && (rd_q != '0);
                        bus.rsp_illegal <= illegal_q;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: decode, result selection, latency,
// backpressure and reset abort, using one EXEC_CYCLES=1 and one =4 instance.
module tb_alu_issue_ctrl;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;

    logic clk;
    logic reset;
    logic reset4;
    int   n_checks;
    int   n_errors;

    alu_issue_ctrl_if bus();
    alu_issue_ctrl_if bus4();

    alu_issue_ctrl #(.EXEC_CYCLES(1)) dut (.clk(clk), .reset(reset), .bus(bus));
    alu_issue_ctrl #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic set_alu(input logic [31:0] a, input logic [31:0] s, input logic [31:0] c);
        bus.adder_rsv      = a;
        bus.shifter_rsv    = s;
        bus.comparator_rsv = c;
    endtask

    task automatic set_req(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.req_instr = instr;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_valid = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) lat = 99;
        check(tag, lat, exp_lat);
    endtask

    // One full transaction on the EXEC_CYCLES=1 instance with rsp_ready held high.
    task automatic run_vec(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] a, input logic [31:0] s,
                           input logic [31:0] c, input logic [31:0] e_op1, input logic [31:0] e_op2,
                           input logic [2:0] e_f3, input logic e_f7, input logic [31:0] e_data,
                           input logic [4:0] e_rd, input logic e_we, input logic e_ill);
        @(negedge clk);
        set_alu(a, s, c);
        set_req(instr, rs1, rs2);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check({tag, "_op1"}, bus.alu_op1, e_op1);
        check({tag, "_op2"}, bus.alu_op2, e_op2);
        check({tag, "_f3"}, 32'(bus.alu_funct3), 32'(e_f3));
        check({tag, "_f7"}, 32'(bus.alu_funct7), 32'(e_f7));
        check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        wait_valid({tag, "_lat"}, 2);
        check({tag, "_data"}, bus.rsp_data, e_data);
        check({tag, "_rd"}, 32'(bus.rsp_rd), 32'(e_rd));
        check({tag, "_we"}, 32'(bus.rsp_we), 32'(e_we));
        check({tag, "_ill"}, 32'(bus.rsp_illegal), 32'(e_ill));
        @(posedge clk);
        #1;
        check({tag, "_retire"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        reset4 = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_instr = '0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.rsp_ready = 1'b0;
        set_alu('0, '0, '0);
        bus4.req_valid = 1'b0;
        bus4.req_instr = '0;
        bus4.req_rs1 = '0;
        bus4.req_rs2 = '0;
        bus4.rsp_ready = 1'b1;
        bus4.adder_rsv = '0;
        bus4.shifter_rsv = '0;
        bus4.comparator_rsv = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_outs", 32'(|{bus.alu_op1, bus.alu_op2, bus.alu_funct3, bus.alu_funct7,
                                bus.rsp_rd, bus.rsp_data, bus.rsp_we, bus.rsp_illegal}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        reset4 = 1'b0;
        #1;
        check("rel_ready", 32'(bus.req_ready), 32'd1);

        run_vec("add", r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd5), 32'd100, 32'd100,
                32'd200, 32'h0000AAAA, 32'h00005555,
                32'd100, 32'd100, 3'b000, 1'b0, 32'd200, 5'd5, 1'b1, 1'b0);
        run_vec("sub", r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd6), 32'd100, 32'd100,
                32'd0, 32'h0000AAAA, 32'h00005555,
                32'd100, 32'd100, 3'b000, 1'b1, 32'd0, 5'd6, 1'b1, 1'b0);
        run_vec("srai", i_type(12'h404, 5'd1, 3'b101, 5'd3, OPIMM), 32'h80000000, 32'h12345678,
                32'h11111111, 32'hF8000000, 32'h22222222,
                32'h80000000, 32'd4, 3'b101, 1'b1, 32'hF8000000, 5'd3, 1'b1, 1'b0);
        run_vec("slti", i_type(12'hFFF, 5'd1, 3'b010, 5'd7, OPIMM), 32'hFFFFFFFE, 32'h0,
                32'h33333333, 32'h44444444, 32'd1,
                32'hFFFFFFFE, 32'hFFFFFFFF, 3'b010, 1'b0, 32'd1, 5'd7, 1'b1, 1'b0);
        run_vec("sltu", r_type(7'h00, 5'd2, 5'd1, 3'b011, 5'd8), 32'd1, 32'hFFFFFFFF,
                32'h55555555, 32'h66666666, 32'd1,
                32'd1, 32'hFFFFFFFF, 3'b011, 1'b0, 32'd1, 5'd8, 1'b1, 1'b0);
        // ORI with bit 30 set in the immediate must not raise funct7.
        run_vec("ori", i_type(12'h400, 5'd1, 3'b110, 5'd9, OPIMM), 32'h0000000F, 32'h0,
                32'h0000040F, 32'h77777777, 32'h88888888,
                32'h0000000F, 32'h00000400, 3'b110, 1'b0, 32'h0000040F, 5'd9, 1'b1, 1'b0);
        run_vec("addi_x0", i_type(12'd5, 5'd1, 3'b000, 5'd0, OPIMM), 32'd10, 32'h0,
                32'd15, 32'h99999999, 32'hAAAAAAAA,
                32'd10, 32'd5, 3'b000, 1'b0, 32'd15, 5'd0, 1'b0, 1'b0);
        run_vec("load", i_type(12'h010, 5'd1, 3'b010, 5'd9, LOAD), 32'd10, 32'd20,
                32'd123, 32'd456, 32'd789,
                32'd0, 32'd0, 3'b000, 1'b0, 32'd0, 5'd9, 1'b0, 1'b1);

        // Backpressure: A stalls in RESP while B is held on the request port.
        @(negedge clk);
        set_alu(32'd7, 32'hDEAD0000, 32'hBEEF0000);
        set_req(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), 32'd3, 32'd4);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        set_req(i_type(12'd1, 5'd1, 3'b000, 5'd2, OPIMM), 32'd50, 32'd0);
        wait_valid("bp_a_lat", 2);
        set_alu(32'd51, 32'hDEAD0000, 32'hBEEF0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_data", bus.rsp_data, 32'd7);
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            check("bp_no_accept", bus.alu_op1, 32'd3);
        end
        check("bp_a_rd", 32'(bus.rsp_rd), 32'd4);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_retire", 32'(bus.rsp_valid), 32'd0);
        check("bp_retire_op1", bus.alu_op1, 32'd3);
        check("bp_ready_after", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("bp_b_op1", bus.alu_op1, 32'd50);
        check("bp_b_op2", bus.alu_op2, 32'd1);
        wait_valid("bp_b_lat", 2);
        check("bp_b_data", bus.rsp_data, 32'd51);
        check("bp_b_rd", 32'(bus.rsp_rd), 32'd2);
        @(posedge clk);
        #1;
        check("bp_b_retire", 32'(bus.rsp_valid), 32'd0);

        // Reset abort on the EXEC_CYCLES=4 instance.
        @(negedge clk);
        bus4.adder_rsv = 32'd11;
        bus4.req_instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd10);
        bus4.req_rs1 = 32'd5;
        bus4.req_rs2 = 32'd6;
        bus4.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        check("r4_accept", bus4.alu_op1, 32'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset4 = 1'b1;
        @(posedge clk);
        #1;
        check("r4_zero", 32'(|{bus4.alu_op1, bus4.alu_op2, bus4.alu_funct3, bus4.alu_funct7,
                               bus4.rsp_valid, bus4.rsp_rd, bus4.rsp_data, bus4.rsp_we,
                               bus4.rsp_illegal}), 32'd0);
        check("r4_ready_rst", 32'(bus4.req_ready), 32'd0);
        @(negedge clk);
        reset4 = 1'b0;
        #1;
        check("r4_ready_rel", 32'(bus4.req_ready), 32'd1);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                seen = seen | bus4.rsp_valid;
            end
            check("r4_no_rsp", 32'(seen), 32'd0);
        end

        // Latency with EXEC_CYCLES=4 is five cycles after accept.
        @(negedge clk);
        bus4.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        begin
            int lat = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                lat++;
                if (bus4.rsp_valid) break;
            end
            if (!bus4.rsp_valid) lat = 99;
            check("r4_lat", lat, 32'd5);
            check("r4_data", bus4.rsp_data, 32'd11);
            check("r4_rd", 32'(bus4.rsp_rd), 32'd10);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
